sobel_frame_sequencer: RTL and testbench

//  Frame-level scheduler for the Sobel edge-detection datapath. On start, walks every interior

---
 rtl/sobel_pkg.sv | 9 +
 rtl/sobel_frame_sequencer_coord.sv | 52 +++++
 rtl/sobel_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel frame sequencer.
package sobel_pkg;
  localparam int IMG_W_DEF    = 64;
  localparam int IMG_H_DEF    = 64;
  localparam int ADDR_W_DEF   = 14;
  localparam int OUT_BASE_DEF = 4096;

  typedef enum logic [2:0] {IDLE, SHIFT, READ, CALC, WAIT, WRITE, DONE} seq_state_t;
endpackage

// File: rtl/sobel_frame_sequencer_coord.sv
// Interior-pixel row/column counter; walks r,c over 1..H-2 / 1..W-2 in raster order.
module pixel_coord_counter #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] r_nxt,
  output logic [CW-1:0] c_nxt,
  output logic          last_col,
  output logic          last_pixel
);
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          last_row;

  assign last_col   = (c_q == CW'(IMG_W - 2));
  assign last_row   = (r_q == RW'(IMG_H - 2));
  assign last_pixel = last_col && last_row;
  assign r_nxt      = r_d;
  assign c_nxt      = c_d;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clr) begin
      r_d = RW'(1);
      c_d = CW'(1);
    end else if (adv) begin
      if (last_col) begin
        c_d = CW'(1);
        r_d = last_row ? RW'(1) : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q <= RW'(1);
      c_q <= CW'(1);
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame scheduler: per interior pixel, fetch 3x3 window columns, run the Sobel engine, write result.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  output logic              win_shift,
  output logic [1:0]        win_row,
  output logic              calc_start,
  input  logic              calc_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  seq_state_t    state_q, state_d;
  logic [1:0]    k_q, k_d, cl_q, cl_d;
  logic          adv, clr, last_col, last_pixel;
  logic [RW-1:0] r_nxt;
  logic [CW-1:0] c_nxt;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  int            rd_lin, wr_lin;

  pixel_coord_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) u_coord (
    .clk(clk), .n_rst(n_rst), .clr(clr), .adv(adv),
    .r_nxt(r_nxt), .c_nxt(c_nxt), .last_col(last_col), .last_pixel(last_pixel)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cl_d    = cl_q;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE:  if (start) begin
               state_d = SHIFT;
               k_d     = 2'd0;
               cl_d    = 2'd2;
             end
      SHIFT: begin
               k_d     = 2'd0;
               state_d = READ;
             end
      READ:  if (rd_valid) begin
               if (k_q == 2'd2) begin
                 if (cl_q != 2'd0) begin
                   cl_d    = cl_q - 2'd1;
                   state_d = SHIFT;
                 end else begin
                   state_d = CALC;
                 end
               end else begin
                 k_d = k_q + 2'd1;
               end
             end
      CALC:  state_d = WAIT;
      WAIT:  if (calc_done) state_d = WRITE;
      WRITE: if (wr_ack) begin
               if (last_pixel) begin
                 state_d = DONE;
               end else begin
                 adv     = 1'b1;
                 cl_d    = last_col ? 2'd2 : 2'd0;
                 state_d = SHIFT;
               end
             end
      DONE:  begin
               clr     = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      k_d     = 2'd0;
      cl_d    = 2'd0;
      adv     = 1'b0;
      clr     = 1'b1;
    end
  end

  // Loaded column lc = c+1-cols_left covers both row start (0,1,2) and mid row (c+1).
  always_comb begin
    rd_lin    = (int'(r_nxt) - 1 + int'(k_d)) * IMG_W + int'(c_nxt) + 1 - int'(cl_d);
    wr_lin    = OUT_BASE + int'(r_nxt) * IMG_W + int'(c_nxt);
    rd_addr_d = (state_d == READ)  ? ADDR_W'(rd_lin) : '0;
    wr_addr_d = (state_d == WRITE) ? ADDR_W'(wr_lin) : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      cl_q       <= 2'd0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      win_shift  <= 1'b0;
      win_row    <= 2'd0;
      calc_start <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cl_q       <= cl_d;
      rd_req     <= (state_d == READ);
      rd_addr    <= rd_addr_d;
      win_shift  <= (state_d == SHIFT);
      win_row    <= (state_d == READ) ? k_d : 2'd0;
      calc_start <= (state_d == CALC);
      wr_req     <= (state_d == WRITE);
      wr_addr    <= wr_addr_d;
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == DONE);
    end
  end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for the Sobel frame sequencer on a 4x4 image with a behavioural memory/engine.
module tb_sobel_frame_sequencer;
  localparam int W = 4, H = 4, AW = 14, OB = 64;

  logic clk = 0, n_rst = 0, start = 0, abort = 0;
  logic rd_valid = 0, calc_done = 0, wr_ack = 0;
  logic rd_req, win_shift, calc_start, wr_req, busy, frame_done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [1:0] win_row;

  always #5 clk = ~clk;

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_BASE(OB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .win_shift(win_shift), .win_row(win_row),
    .calc_start(calc_start), .calc_done(calc_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {int rd; int wr; int cd; bit nz; int exp_cyc;} vec_t;
  vec_t tbl[4];
  int exp_rd[24] = '{0,4,8,1,5,9,2,6,10, 3,7,11, 4,8,12,5,9,13,6,10,14, 7,11,15};
  int exp_wr[4]  = '{69,70,73,74};

  int total = 0, bad = 0;
  int rd_dly = 0, wr_dly = 0, cd_dly = 1;
  bit noise = 0;
  int rd_log[$], wr_log[$];
  int cyc = 0, c0 = 0, fd_cnt = 0, fd_cyc = -1, ws_cnt = 0, cs_n = 0;
  int stab_bad = 0, gap_bad = 0, cs_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, rd_hold = 0, wr_hold = 0, cd_cnt = 0;
  bit cd_pend = 0, wr_prev = 0;

  // Memory/engine responder and monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rd_valid) begin rd_log.push_back(rd_hold); rd_cnt = 0; end
    if (wr_ack)   begin wr_log.push_back(wr_hold); wr_cnt = 0; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc - c0; end
    if (win_shift) ws_cnt++;
    if (wr_req && !wr_prev && (cyc - cs_cyc != cd_dly + 1)) gap_bad++;
    wr_prev = wr_req;
    if (rd_req) begin
      if (rd_cnt == 0) rd_hold = int'(rd_addr);
      else if (int'(rd_addr) != rd_hold) stab_bad++;
      rd_valid = (rd_cnt >= rd_dly);
      rd_cnt++;
    end else begin rd_valid = 0; rd_cnt = 0; end
    if (wr_req) begin
      if (wr_cnt == 0) wr_hold = int'(wr_addr);
      else if (int'(wr_addr) != wr_hold) stab_bad++;
      wr_ack = (wr_cnt >= wr_dly);
      wr_cnt++;
    end else begin wr_ack = 0; wr_cnt = 0; end
    calc_done = 0;
    if (calc_start) begin cd_pend = 1; cd_cnt = 0; cs_cyc = cyc; cs_n++; end
    else if (cd_pend) begin
      cd_cnt++;
      if (cd_cnt >= cd_dly) begin calc_done = 1; cd_pend = 0; end
    end
    if (noise && (rd_req || calc_start)) calc_done = 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete();
    fd_cnt = 0; fd_cyc = -1; ws_cnt = 0; stab_bad = 0; gap_bad = 0; cs_n = 0;
  endtask

  task automatic go();
    start = 1;
    c0 = cyc + 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin tick(1); n++; end
    if (fd_cnt == 0) chk({nm, "_timeout"}, 0, 1);
    tick(3);
  endtask

  task automatic check_frame(input string nm, input int exp_cyc);
    chk({nm, "_rd_n"}, rd_log.size(), 24);
    for (int i = 0; i < 24 && i < rd_log.size(); i++)
      chk($sformatf("%s_rd%0d", nm, i), rd_log[i], exp_rd[i]);
    chk({nm, "_wr_n"}, wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk($sformatf("%s_wr%0d", nm, i), wr_log[i], exp_wr[i]);
    chk({nm, "_shifts"}, ws_cnt, 8);
    chk({nm, "_done_n"}, fd_cnt, 1);
    chk({nm, "_done_cyc"}, fd_cyc, exp_cyc);
    chk({nm, "_stable"}, stab_bad, 0);
    chk({nm, "_calc_gap"}, gap_bad, 0);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 0, 45};
    tbl[1] = '{3, 2, 1, 0, 125};
    tbl[2] = '{0, 0, 3, 1, 53};
    tbl[3] = '{1, 0, 1, 0, 69};

    // Reset state
    tick(2);
    n_rst = 1;
    tick(2);
    chk("rst_ctrl", int'({rd_req, win_shift, calc_start, wr_req, busy, frame_done}), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_win_row", int'(win_row), 0);

    // Reset asserted mid-READ
    clear_logs();
    rd_dly = 5;
    go();
    begin
      int n = 0;
      while (!rd_req && n < 20) begin tick(1); n++; end
    end
    chk("rst_mid_reached_read", int'(rd_req), 1);
    tick(1);
    n_rst = 0;
    #1;
    chk("rst_mid_rd_req", int'(rd_req), 0);
    chk("rst_mid_busy", int'(busy), 0);
    tick(1);
    n_rst = 1;
    rd_dly = 0;
    tick(10);
    chk("rst_mid_no_done", fd_cnt, 0);
    chk("rst_mid_idle", int'(busy), 0);

    // start and abort together in IDLE
    clear_logs();
    start = 1; abort = 1;
    tick(1);
    start = 0; abort = 0;
    tick(2);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_shift", ws_cnt, 0);

    // Table: full frames under different memory/engine timing
    foreach (tbl[i]) begin
      rd_dly = tbl[i].rd; wr_dly = tbl[i].wr; cd_dly = tbl[i].cd; noise = tbl[i].nz;
      clear_logs();
      go();
      wait_done($sformatf("v%0d", i), 2000);
      check_frame($sformatf("v%0d", i), tbl[i].exp_cyc);
    end
    noise = 0; rd_dly = 0; wr_dly = 0;

    // Abort during WAIT of pixel 3, then a clean restart
    cd_dly = 6;
    clear_logs();
    go();
    begin
      int n = 0;
      while (cs_n < 3 && n < 500) begin tick(1); n++; end
    end
    chk("abort_reached_calc3", cs_n, 3);
    abort = 1;
    tick(1);
    abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_req", int'(wr_req), 0);
    tick(12);
    chk("abort_wr_n", wr_log.size(), 2);
    if (wr_log.size() == 2) chk("abort_wr_last", wr_log[1], 70);
    chk("abort_no_done", fd_cnt, 0);
    chk("abort_still_idle", int'(busy), 0);
    cd_dly = 1;
    clear_logs();
    go();
    wait_done("restart", 2000);
    check_frame("restart", 45);

    // start pulsed repeatedly while busy
    clear_logs();
    go();
    for (int i = 0; i < 6; i++) begin
      tick(5);
      start = 1;
      tick(1);
      start = 0;
    end
    wait_done("restart_spam", 2000);
    check_frame("spam", 45);
    tick(10);
    chk("spam_done_once", fd_cnt, 1);
    chk("spam_writes", wr_log.size(), 4);
    chk("spam_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
